// File: rtl/avl_sim_pkg.sv
// rtl/avl_sim_pkg.sv - shared constants, LFSR step and protocol-error causes for the Avalon responder
package avl_sim_pkg;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Reasons the sticky protocol-error flag can be raised
    typedef enum logic [1:0] {
        PERR_NONE    = 2'd0,
        PERR_RD_WR   = 2'd1,
        PERR_BURST   = 2'd2,
        PERR_BYTE_EN = 2'd3
    } perr_cause_e;

    // One LFSR step: shift left, feedback parity of the tapped bits into bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/avl_resp_fifo.sv
// rtl/avl_resp_fifo.sv - in-order response FIFO with count, full and empty
module avl_resp_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty when the index bits match
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is only allowed when the head leaves in the same cycle
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer next-state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/avl_bus_slave_resp_model.sv
// rtl/avl_bus_slave_resp_model.sv - Avalon-style slave responder with latency pipe, stalls and accounting
module avl_bus_slave_resp_model
    import avl_sim_pkg::*;
#(
    parameter int          DEPTH        = 8,
    parameter int          LATENCY      = 2,
    parameter int          RANDOM_STALL = 1,
    parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT,
    parameter int          ADDR_W       = 32,
    parameter int          BURST_W      = 8
) (
    input  logic               clk_i,
    input  logic               rest_ni,
    input  logic [31:0]        value_i,
    input  logic [ADDR_W-1:0]  avl_address_i,
    input  logic [3:0]         avl_byte_en_i,
    input  logic               avl_read_i,
    input  logic               avl_write_i,
    input  logic [31:0]        avl_write_data_i,
    input  logic               avl_begin_burst_transfer_i,
    input  logic [BURST_W-1:0] avl_burst_count_i,
    input  logic               avl_resp_ready_i,
    output logic               avl_request_ready_o,
    output logic [31:0]        avl_read_data_o,
    output logic               avl_read_data_valid_o,
    output logic [31:0]        rd_accept_cnt_o,
    output logic [31:0]        wr_accept_cnt_o,
    output logic [31:0]        rd_resp_cnt_o,
    output logic               proto_err_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          req;
    logic          accept;
    logic          rd_accept;
    logic          wr_accept;
    logic          push;
    logic          pop;
    logic          head_load;
    logic          proto_viol;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_rdata;

    logic          ready_q, ready_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [CW-1:0] out_q, out_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [31:0]   rd_acc_q, rd_acc_d;
    logic [31:0]   wr_acc_q, wr_acc_d;
    logic [31:0]   rd_resp_q, rd_resp_d;
    logic          perr_q, perr_d;

    // Address, write payload and burst length carry no meaning for this responder
    logic unused_inputs;
    assign unused_inputs = ^{avl_address_i, avl_write_data_i, avl_burst_count_i, fifo_full, fifo_rdata};

    assign req        = avl_read_i | avl_write_i;
    assign accept     = req & ready_q;
    // A request with read high is a read even when write is also high
    assign rd_accept  = accept & avl_read_i;
    assign wr_accept  = accept & ~avl_read_i;
    assign pop        = ~fifo_empty & avl_resp_ready_i;
    assign proto_viol = (avl_read_i & avl_write_i) | avl_begin_burst_transfer_i
                      | (req & (avl_byte_en_i == 4'b0000));
    // The head changes when an entry lands in an empty FIFO or a pop exposes the next one
    assign head_load  = (fifo_empty & push) | (pop & ((fifo_count > CW'(1)) | push));

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign push = rd_accept;
        end else begin : g_pipe
            logic [LATENCY-2:0] pipe_q;
            // Shift accepted-read tokens toward the response FIFO
            always_ff @(posedge clk_i or negedge rest_ni) begin
                if (!rest_ni) pipe_q <= '0;
                else          pipe_q <= (LATENCY-1)'({pipe_q, rd_accept});
            end
            assign push = pipe_q[LATENCY-2];
        end
    endgenerate

    avl_resp_fifo #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rest_ni),
        .push_i  (push),
        .wdata_i (value_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state: ready is derived from next outstanding count and next LFSR so it is fully registered
    always_comb begin
        lfsr_d    = lfsr_next(lfsr_q);
        out_d     = out_q + CW'(rd_accept) - CW'(pop);
        ready_d   = (out_d != CW'(DEPTH)) & ((RANDOM_STALL == 0) | (lfsr_d[1:0] != 2'b00));
        rd_data_d = head_load ? value_i : rd_data_q;
        rd_acc_d  = rd_acc_q + 32'(rd_accept);
        wr_acc_d  = wr_acc_q + 32'(wr_accept);
        rd_resp_d = rd_resp_q + 32'(pop);
        perr_d    = perr_q | proto_viol;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk_i or negedge rest_ni) begin
        if (!rest_ni) begin
            ready_q   <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            out_q     <= '0;
            rd_data_q <= '0;
            rd_acc_q  <= '0;
            wr_acc_q  <= '0;
            rd_resp_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            lfsr_q    <= lfsr_d;
            out_q     <= out_d;
            rd_data_q <= rd_data_d;
            rd_acc_q  <= rd_acc_d;
            wr_acc_q  <= wr_acc_d;
            rd_resp_q <= rd_resp_d;
            perr_q    <= perr_d;
        end
    end

    assign avl_request_ready_o   = ready_q;
    assign avl_read_data_o       = rd_data_q;
    assign avl_read_data_valid_o = ~fifo_empty;
    assign rd_accept_cnt_o       = rd_acc_q;
    assign wr_accept_cnt_o       = wr_acc_q;
    assign rd_resp_cnt_o         = rd_resp_q;
    assign proto_err_o           = perr_q;

endmodule

// File: tb/tb_avl_bus_slave_resp_model.sv
// tb/tb_avl_bus_slave_resp_model.sv - directed and random self-checking bench for the Avalon responder
module tb_avl_bus_slave_resp_model;
    import avl_sim_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] value;
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic        read;
    logic        write;
    logic [31:0] write_data;
    logic        bbt;
    logic [7:0]  burst_count;
    logic        resp_ready;

    logic        ready, rvalid, perr;
    logic [31:0] rdata, rd_acc, wr_acc, rd_resp;
    logic        ready_s, rvalid_s, perr_s;
    logic [31:0] rdata_s, rd_acc_s, wr_acc_s, rd_resp_s;

    int checks = 0;
    int passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    avl_bus_slave_resp_model #(.DEPTH(8), .LATENCY(2), .RANDOM_STALL(0)) dut (
        .clk_i(clk), .rest_ni(rst_n), .value_i(value), .avl_address_i(address),
        .avl_byte_en_i(byte_en), .avl_read_i(read), .avl_write_i(write),
        .avl_write_data_i(write_data), .avl_begin_burst_transfer_i(bbt),
        .avl_burst_count_i(burst_count), .avl_resp_ready_i(resp_ready),
        .avl_request_ready_o(ready), .avl_read_data_o(rdata), .avl_read_data_valid_o(rvalid),
        .rd_accept_cnt_o(rd_acc), .wr_accept_cnt_o(wr_acc), .rd_resp_cnt_o(rd_resp),
        .proto_err_o(perr)
    );

    avl_bus_slave_resp_model #(.DEPTH(4), .LATENCY(1), .RANDOM_STALL(1)) dut_s (
        .clk_i(clk), .rest_ni(rst_n), .value_i(value), .avl_address_i(address),
        .avl_byte_en_i(byte_en), .avl_read_i(read), .avl_write_i(write),
        .avl_write_data_i(write_data), .avl_begin_burst_transfer_i(bbt),
        .avl_burst_count_i(burst_count), .avl_resp_ready_i(resp_ready),
        .avl_request_ready_o(ready_s), .avl_read_data_o(rdata_s), .avl_read_data_valid_o(rvalid_s),
        .rd_accept_cnt_o(rd_acc_s), .wr_accept_cnt_o(wr_acc_s), .rd_resp_cnt_o(rd_resp_s),
        .proto_err_o(perr_s)
    );

    task automatic idle_inputs();
        read = 0; write = 0; bbt = 0; byte_en = 4'hF; resp_ready = 0;
        value = 0; address = 0; write_data = 0; burst_count = 8'd1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Pops everything; the first head holds first_exp, each later head holds the value driven at its pop edge
    task automatic drain(input logic [31:0] first_exp, output int n, output int bad);
        logic [31:0] exp;
        exp = first_exp; n = 0; bad = 0;
        read = 0; write = 0; resp_ready = 1;
        for (int i = 0; i < 20; i++) begin
            if (rvalid) begin n++; if (rdata !== exp) bad++; end
            value = 32'hD000_0000 + 32'(i);
            exp = value;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b0)    $display("FAIL reset_ready: got %0b want 0", ready);    else passed++;
        checks++; if (ready_s !== 1'b0)  $display("FAIL reset_ready_s: got %0b want 0", ready_s); else passed++;
        checks++; if (rvalid !== 1'b0)   $display("FAIL reset_valid: got %0b want 0", rvalid);   else passed++;
        checks++; if (rdata !== 32'h0)   $display("FAIL reset_rdata: got %h want 0", rdata);     else passed++;
        checks++; if (rd_acc !== 32'h0)  $display("FAIL reset_rd_acc: got %0d want 0", rd_acc);  else passed++;
        checks++; if (wr_acc !== 32'h0)  $display("FAIL reset_wr_acc: got %0d want 0", wr_acc);  else passed++;
        checks++; if (rd_resp !== 32'h0) $display("FAIL reset_rd_resp: got %0d want 0", rd_resp); else passed++;
        checks++; if (perr !== 1'b0)     $display("FAIL reset_perr: got %0b want 0", perr);      else passed++;
        rst_n = 1;
        @(negedge clk);
        checks++; if (ready !== 1'b1)    $display("FAIL release_ready: got %0b want 1", ready);  else passed++;
    endtask

    task automatic test_write();
        write = 1; address = 32'h0000_0040; write_data = 32'hCAFE_F00D;
        @(negedge clk);
        write = 0;
        checks++; if (wr_acc !== 32'd1) $display("FAIL write_wr_acc: got %0d want 1", wr_acc); else passed++;
        checks++; if (rd_acc !== 32'd0) $display("FAIL write_rd_acc: got %0d want 0", rd_acc); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (rvalid !== 1'b0)  $display("FAIL write_no_resp: got %0b want 0", rvalid); else passed++;
        checks++; if (perr !== 1'b0)    $display("FAIL write_perr: got %0b want 0", perr);      else passed++;
    endtask

    task automatic test_single_read();
        apply_reset();
        read = 1; value = 32'h1234_5678; resp_ready = 1;
        @(negedge clk);
        read = 0;
        checks++; if (rvalid !== 1'b0)          $display("FAIL single_early_valid: got %0b want 0", rvalid); else passed++;
        checks++; if (rvalid_s !== 1'b1)        $display("FAIL lat1_valid: got %0b want 1", rvalid_s); else passed++;
        checks++; if (rdata_s !== 32'h1234_5678) $display("FAIL lat1_rdata: got %h want 12345678", rdata_s); else passed++;
        @(negedge clk);
        checks++; if (rvalid !== 1'b1)          $display("FAIL single_valid: got %0b want 1", rvalid); else passed++;
        checks++; if (rdata !== 32'h1234_5678)  $display("FAIL single_rdata: got %h want 12345678", rdata); else passed++;
        @(negedge clk);
        checks++; if (rvalid !== 1'b0)          $display("FAIL single_popped: got %0b want 0", rvalid); else passed++;
        checks++; if (rd_resp !== 32'd1)        $display("FAIL single_rd_resp: got %0d want 1", rd_resp); else passed++;
        checks++; if (rd_acc !== 32'd1)         $display("FAIL single_rd_acc: got %0d want 1", rd_acc); else passed++;
    endtask

    task automatic test_back_to_back();
        int n_acc, n, bad;
        apply_reset();
        read = 1; value = 32'h0000_00A0; resp_ready = 0;
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (ready) n_acc++;
            @(negedge clk);
        end
        checks++; if (n_acc != 8)      $display("FAIL fill_accepts: got %0d want 8", n_acc); else passed++;
        checks++; if (ready !== 1'b0)  $display("FAIL fill_ready_low: got %0b want 0", ready); else passed++;
        checks++; if (rd_acc !== 32'd8) $display("FAIL fill_rd_acc: got %0d want 8", rd_acc); else passed++;
        drain(32'h0000_00A0, n, bad);
        checks++; if (n != 8)           $display("FAIL fill_drain_count: got %0d want 8", n); else passed++;
        checks++; if (bad != 0)         $display("FAIL fill_drain_data: got %0d bad want 0", bad); else passed++;
        checks++; if (rd_resp !== 32'd8) $display("FAIL fill_rd_resp: got %0d want 8", rd_resp); else passed++;
        checks++; if (ready !== 1'b1)   $display("FAIL fill_reopen: got %0b want 1", ready); else passed++;
    endtask

    task automatic test_push_pop();
        int n, bad;
        apply_reset();
        read = 1; value = 32'h0000_0011; resp_ready = 0;
        repeat (5) @(negedge clk);
        read = 0;
        checks++; if (dut.u_fifo.count_o !== 4'd4) $display("FAIL pp_count_before: got %0d want 4", dut.u_fifo.count_o); else passed++;
        checks++; if (rdata !== 32'h11)            $display("FAIL pp_head_before: got %h want 11", rdata); else passed++;
        value = 32'h0000_0022; resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        checks++; if (dut.u_fifo.count_o !== 4'd4) $display("FAIL pp_count_after: got %0d want 4", dut.u_fifo.count_o); else passed++;
        checks++; if (rdata !== 32'h22)            $display("FAIL pp_head_after: got %h want 22", rdata); else passed++;
        checks++; if (rd_resp !== 32'd1)           $display("FAIL pp_rd_resp: got %0d want 1", rd_resp); else passed++;
        drain(32'h0000_0022, n, bad);
        checks++; if (n != 4)            $display("FAIL pp_drain_count: got %0d want 4", n); else passed++;
        checks++; if (bad != 0)          $display("FAIL pp_drain_data: got %0d bad want 0", bad); else passed++;
        checks++; if (rd_resp !== 32'd5) $display("FAIL pp_rd_resp_total: got %0d want 5", rd_resp); else passed++;
    endtask

    task automatic test_proto_err();
        perr_cause_e cause;
        for (int c = 1; c < 4; c++) begin
            cause = perr_cause_e'(c);
            apply_reset();
            checks++; if (perr !== 1'b0) $display("FAIL perr_clear_%s: got %0b want 0", cause.name(), perr); else passed++;
            case (cause)
                PERR_RD_WR: begin read = 1; write = 1; end
                PERR_BURST: begin write = 1; bbt = 1; end
                default:    begin write = 1; byte_en = 4'h0; end
            endcase
            @(negedge clk);
            read = 0; write = 0; bbt = 0; byte_en = 4'hF;
            repeat (3) @(negedge clk);
            checks++; if (perr !== 1'b1) $display("FAIL perr_set_%s: got %0b want 1", cause.name(), perr); else passed++;
            checks++; if (rd_acc !== ((cause == PERR_RD_WR) ? 32'd1 : 32'd0))
                $display("FAIL perr_rd_acc_%s: got %0d want %0d", cause.name(), rd_acc, (cause == PERR_RD_WR) ? 1 : 0); else passed++;
            checks++; if (wr_acc !== ((cause == PERR_RD_WR) ? 32'd0 : 32'd1))
                $display("FAIL perr_wr_acc_%s: got %0d want %0d", cause.name(), wr_acc, (cause == PERR_RD_WR) ? 0 : 1); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        read = 1; value = 32'h0000_0077; resp_ready = 0;
        repeat (3) @(negedge clk);
        read = 0;
        checks++; if (rvalid !== 1'b1)  $display("FAIL mid_pre_valid: got %0b want 1", rvalid); else passed++;
        checks++; if (rd_acc !== 32'd3) $display("FAIL mid_pre_rd_acc: got %0d want 3", rd_acc); else passed++;
        #2 rst_n = 0;
        #1;
        checks++; if (rvalid !== 1'b0)  $display("FAIL mid_valid_drop: got %0b want 0", rvalid); else passed++;
        checks++; if (rd_acc !== 32'd0) $display("FAIL mid_rd_acc_clear: got %0d want 0", rd_acc); else passed++;
        checks++; if (ready !== 1'b0)   $display("FAIL mid_ready_low: got %0b want 0", ready); else passed++;
        @(negedge clk);
        rst_n = 1; resp_ready = 1;
        n = 0;
        repeat (10) begin @(negedge clk); if (rvalid) n++; end
        checks++; if (n != 0)            $display("FAIL mid_stale_resp: got %0d want 0", n); else passed++;
        checks++; if (rd_resp !== 32'd0) $display("FAIL mid_rd_resp: got %0d want 0", rd_resp); else passed++;
    endtask

    task automatic test_random();
        int rd_m, wr_m, pops, hold_bad, op;
        logic pv, pp;
        logic [31:0] pd;
        apply_reset();
        rd_m = 0; wr_m = 0; pops = 0; hold_bad = 0;
        pv = 0; pp = 0; pd = 0;
        for (int i = 0; i < 10000; i++) begin
            if (pv && !pp && (!rvalid_s || rdata_s !== pd)) hold_bad++;
            op = $urandom_range(0, 3);
            read = (op == 1) || (op == 3);
            write = (op == 2);
            resp_ready = 1'($urandom_range(0, 1));
            value = $urandom; address = $urandom; write_data = $urandom;
            if (ready_s && (read || write)) begin
                if (read) rd_m++; else wr_m++;
            end
            if (rvalid_s && resp_ready) pops++;
            pv = rvalid_s; pd = rdata_s; pp = rvalid_s & resp_ready;
            @(negedge clk);
        end
        read = 0; write = 0; resp_ready = 1;
        for (int i = 0; i < 40; i++) begin
            if (rvalid_s) pops++;
            @(negedge clk);
        end
        checks++; if (hold_bad != 0)          $display("FAIL rand_hold: got %0d violations want 0", hold_bad); else passed++;
        checks++; if (rd_acc_s !== 32'(rd_m)) $display("FAIL rand_rd_acc: got %0d want %0d", rd_acc_s, rd_m); else passed++;
        checks++; if (wr_acc_s !== 32'(wr_m)) $display("FAIL rand_wr_acc: got %0d want %0d", wr_acc_s, wr_m); else passed++;
        checks++; if (rd_resp_s !== 32'(rd_m)) $display("FAIL rand_rd_resp: got %0d want %0d", rd_resp_s, rd_m); else passed++;
        checks++; if (pops != rd_m)           $display("FAIL rand_pops: got %0d want %0d", pops, rd_m); else passed++;
        checks++; if (rvalid_s !== 1'b0)      $display("FAIL rand_drained: got %0b want 0", rvalid_s); else passed++;
        checks++; if (perr_s !== 1'b0)        $display("FAIL rand_perr: got %0b want 0", perr_s); else passed++;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_write();
        test_single_read();
        test_back_to_back();
        test_push_pop();
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/avl_bus_slave_resp_model.md
# avl_bus_slave_resp_model

Downstream responder for the Avalon-style `i_avl_bus` used by the CPU bench environment. It accepts random request streams from a bus master, applies pseudo-random back-pressure, and returns every accepted read with `read_data = value` after a fixed pipeline latency. Out-of-order data cannot occur, because responses pass through a bounded in-order queue. It also keeps accept/response counters and a sticky protocol-error flag, so the paired master's data checks and bus-level accounting can be cross-checked.

## Interface
- `DEPTH`, default 8: maximum outstanding reads (in-flight plus queued); power of two, ≥2.
- `LATENCY`, default 2: cycles from read acceptance to response eligibility; ≥1.
- `RANDOM_STALL`, default 1: 1 enables LFSR-driven `request_ready` gaps; 0 means ready whenever not full.
- `LFSR_SEED`, default 16'hACE1: nonzero reset value of the stall LFSR.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rest`  in  1: reset, asynchronous and active-low.
- `value`  in  32: data returned on every read response; sampled at response issue.
- `avl_s`  `i_avl_bus.slave`  n/a: slave side of the bus.
  - Inputs used: `address`, `byte_en`, `read`, `write`, `write_data`, `begin_burst_transfer`, `burst_count`, `resp_ready`.
  - Outputs driven: `request_ready`, `read_data`, `read_data_valid`.
- `rd_accept_cnt`  out  32: number of accepted reads.
- `wr_accept_cnt`  out  32: number of accepted writes.
- `rd_resp_cnt`  out  32: number of completed read responses.
- `proto_err`  out  1: sticky protocol-violation flag.

## Operation
- Accept: a request is accepted in a cycle where (`read` | `write`) & `request_ready`.
- `request_ready` = !full & (!RANDOM_STALL | lfsr[1:0]!=2'b00). It is registered from the next-state values, so it never depends combinationally on `read`/`write`.
- Outstanding count = reads in the latency pipe + reads in the FIFO. `full` means outstanding == DEPTH, evaluated on next-state.
- Read accept: a token enters a LATENCY-stage valid shift pipe. When the token exits the pipe it is pushed into the response FIFO.
- Write accept: `wr_accept_cnt`++. No response is generated and `write_data` is discarded.
- Response: `read_data_valid` = FIFO not empty.
  - `read_data` is captured from `value` when an entry becomes head and is held stable until popped.
  - Pop occurs on `read_data_valid` & `resp_ready`; each pop does `rd_resp_cnt`++.
- `proto_err` is set, and held until reset, on any of:
  - `read` & `write` both high;
  - `begin_burst_transfer` high;
  - `byte_en`==0 while a request is asserted.
- A protocol-violating request is still accepted as a read if `read` is high; otherwise it is treated as a write.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle.

## Timing
- Reset values:
  - `request_ready`=0 during reset; it becomes 1 on the first edge after release, subject to the LFSR.
  - `read_data_valid`=0, `read_data`=0.
  - All counters 0, `proto_err`=0.
  - LFSR=LFSR_SEED; pipe and FIFO empty.
- Latency: a read accepted at edge k gives `read_data_valid`=1 no earlier than the cycle after edge k+LATENCY-1. With LATENCY=1 and an empty FIFO, valid is high in the cycle following acceptance.
- Ordering: responses are strictly in accept order. There is one response per accepted read, and none is ever dropped or duplicated.
- Hold: once `read_data_valid` is high, it and `read_data` remain unchanged until a pop.
- Full: at outstanding == DEPTH, `request_ready`=0. A pop in the same cycle as the last accept still leaves `request_ready` low for that cycle; it reopens next cycle.
- Simultaneous push and pop: the FIFO count is unchanged; the pop takes the old head and the new entry enters behind it.
- Pointer wrap: FIFO pointers are log2(DEPTH)+1 bits wide, so full and empty are distinguished by the MSB.
- Counter wrap: counters wrap modulo 2^32.
- Reset mid-operation: asynchronous assertion immediately clears all state and drops `read_data_valid`, including for in-flight reads. Nothing is replayed after release.

## Structure
- Package `avl_sim_pkg`: the LFSR tap mask and seed default, plus a `proto_err` cause enum used by bench assertions.
- Sub-module `avl_resp_fifo`: a synchronous FIFO with parameter DEPTH and 32-bit data, providing `count`, `full` and `empty`. The top level holds the latency pipe, LFSR, counters and error logic.

## Test plan
- Single read: RANDOM_STALL=0, LATENCY=2, `value`=32'h1234_5678, `resp_ready`=1. Expect valid two cycles after accept, `read_data`=32'h1234_5678 and `rd_resp_cnt`=1.
- Back-pressure fill: DEPTH=8, `resp_ready`=0, continuous reads. Expect exactly 8 accepts, then `request_ready`=0. Raising `resp_ready` then drains 8 responses in order and reopens `request_ready`.
- Mixed random traffic: 10k cycles, random `resp_ready`, stalls enabled, reads and writes interleaved. Expect `rd_accept_cnt`==`rd_resp_cnt` after the drain, `proto_err`=0, and no valid-high data change without a pop.
- Simultaneous push and pop: with the FIFO at 4 entries, accept and pop in the same cycle. Expect the count to stay at 4, the head to advance and order to be preserved.
- Protocol error: drive `read`=`write`=1 for one cycle. Expect `proto_err`=1, held until reset. Drive `begin_burst_transfer`=1 after a reset; expect `proto_err`=1 again.
- Reset mid-operation: assert `rest` with 3 reads in the pipe or FIFO. Expect `read_data_valid`=0 immediately and counters at 0. After release, no stale response appears.
